// File: rtl/sid_filt_pkg.sv
// Shared types and constants for the SID filter input feeder.
package sid_filt_pkg;

  localparam int FILT_LAT_DEFAULT = 11;

  localparam int VOICE_W  = 12;
  localparam int FC_W     = 11;
  localparam int REG_W    = 8;
  localparam int SAMPLE_W = 18;
  localparam int DROP_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WAIT    = 2'd3
  } feeder_state_e;

  // Everything the filter reads during one computation, frozen together.
  typedef struct packed {
    logic [VOICE_W-1:0] voice1;
    logic [VOICE_W-1:0] voice2;
    logic [VOICE_W-1:0] voice3;
    logic [VOICE_W-1:0] ext;
    logic [FC_W-1:0]    fc;
    logic [REG_W-1:0]   res_filt;
    logic [REG_W-1:0]   mode_vol;
  } snapshot_t;

endpackage

// File: rtl/sid_filter_feeder_if.sv
// Filter-side sample bus plus the one-entry result stream to the mixer.
interface sid_filter_feeder_if;
  import sid_filt_pkg::*;

  logic [VOICE_W-1:0]  voice1;
  logic [VOICE_W-1:0]  voice2;
  logic [VOICE_W-1:0]  voice3;
  logic [VOICE_W-1:0]  ext_out;
  logic [FC_W-1:0]     fc;
  logic [REG_W-1:0]    res_filt;
  logic [REG_W-1:0]    mode_vol;
  logic                input_valid;
  logic [SAMPLE_W-1:0] filt_sound;

  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_valid;
  logic                sample_ready;

  // Feeder side: drives the filter inputs and the mixer stream.
  modport master (
    output voice1, voice2, voice3, ext_out, fc, res_filt, mode_vol,
    output input_valid,
    input  filt_sound,
    output sample_out, sample_valid,
    input  sample_ready
  );

  // Filter/mixer side.
  modport slave (
    input  voice1, voice2, voice3, ext_out, fc, res_filt, mode_vol,
    input  input_valid,
    output filt_sound,
    input  sample_out, sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/sid_sample_skid.sv
// One-entry result buffer; a push onto an unconsumed entry overwrites it
// and raises a single-cycle drop pulse.
module sid_sample_skid
  import sid_filt_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_drop
);

  logic                r_valid;
  logic [SAMPLE_W-1:0] r_data;

  // Overwrite only loses data when the mixer is not taking the old entry.
  assign o_drop  = i_push & r_valid & ~i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Entry register: a push always wins; ready alone just empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sid_filter_feeder.sv
// Snapshots the filter inputs on each sample tick, launches the filter with
// a one-clock input_valid no faster than FILT_LAT apart, and hands results
// to the mixer through a one-entry buffer.
module sid_filter_feeder
  import sid_filt_pkg::*;
#(
  parameter int FILT_LAT      = FILT_LAT_DEFAULT,
  parameter bit PRIME_DISCARD = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [VOICE_W-1:0]  voice1_in,
  input  logic [VOICE_W-1:0]  voice2_in,
  input  logic [VOICE_W-1:0]  voice3_in,
  input  logic [VOICE_W-1:0]  ext_in,
  input  logic [FC_W-1:0]     fc_in,
  input  logic [REG_W-1:0]    res_filt_in,
  input  logic [REG_W-1:0]    mode_vol_in,
  sid_filter_feeder_if.master bus,
  output logic [DROP_W-1:0]   drop_cnt
);

  if (FILT_LAT < 3) begin : g_bad_filt_lat
    $error("sid_filter_feeder: FILT_LAT must be at least 3");
  end

  // LAUNCH and CAPTURE take two of the FILT_LAT clocks and the IDLE exit
  // edge takes one, leaving FILT_LAT-3 WAIT cycles.
  localparam int CW       = $clog2(FILT_LAT);
  localparam int WAIT_CYC = FILT_LAT - 3;
  localparam int CNT_INIT = (FILT_LAT > 3) ? (FILT_LAT - 4) : 0;

  feeder_state_e     r_state;
  feeder_state_e     w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              r_pending;
  logic              r_primed;
  snapshot_t         r_snap;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_launch_go;
  logic              w_busy_tick;
  logic              w_tick_drop;
  logic              w_push;
  logic              w_skid_drop;
  logic [1:0]        w_drop_inc;
  logic              w_skid_valid;
  logic [SAMPLE_W-1:0] w_skid_data;

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] cnt,
                                                input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

  assign w_launch_go = (r_state == ST_IDLE) && (sample_tick || r_pending);
  assign w_busy_tick = sample_tick && (r_state != ST_IDLE);
  assign w_tick_drop = w_busy_tick && r_pending;
  assign w_push      = (r_state == ST_CAPTURE) && (r_primed || !PRIME_DISCARD);
  assign w_drop_inc  = {1'b0, w_tick_drop} + {1'b0, w_skid_drop};

  // Next-state and WAIT countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_launch_go) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (WAIT_CYC == 0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(CNT_INIT);
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter, pending-tick and prime flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_primed  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_launch_go)      r_pending <= 1'b0;
      else if (w_busy_tick) r_pending <= 1'b1;
      if (r_state == ST_CAPTURE) r_primed <= 1'b1;
    end
  end

  // Snapshot loads only on IDLE exit, so it is frozen for a whole computation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
    end else if (w_launch_go) begin
      r_snap.voice1   <= voice1_in;
      r_snap.voice2   <= voice2_in;
      r_snap.voice3   <= voice3_in;
      r_snap.ext      <= ext_in;
      r_snap.fc       <= fc_in;
      r_snap.res_filt <= res_filt_in;
      r_snap.mode_vol <= mode_vol_in;
    end
  end

  // Lost ticks and overwritten results can coincide, so add both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else        r_drop_cnt <= sat_add(r_drop_cnt, w_drop_inc);
  end

  sid_sample_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.filt_sound),
    .i_ready (bus.sample_ready),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_drop  (w_skid_drop)
  );

  assign bus.voice1       = r_snap.voice1;
  assign bus.voice2       = r_snap.voice2;
  assign bus.voice3       = r_snap.voice3;
  assign bus.ext_out      = r_snap.ext;
  assign bus.fc           = r_snap.fc;
  assign bus.res_filt     = r_snap.res_filt;
  assign bus.mode_vol     = r_snap.mode_vol;
  assign bus.input_valid  = (r_state == ST_LAUNCH);
  assign bus.sample_out   = w_skid_data;
  assign bus.sample_valid = w_skid_valid;
  assign drop_cnt         = r_drop_cnt;

endmodule
